// File: rtl/adc_spi_pkg.sv
// Shared types and constants for the ADC SPI scheduler: FSM states,
// init-table entry layout and the ADC power-up register sequence.
package adc_spi_pkg;

    localparam int unsigned ADC_ADDR_W      = 8;
    localparam int unsigned ADC_DATA_W      = 16;
    localparam int unsigned ADC_INIT_LEN    = 8;
    localparam int unsigned ADC_TIMEOUT_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE,
        INIT_ISSUE,
        INIT_WAIT,
        ISSUE,
        WAIT
    } state_t;

    typedef struct packed {
        logic [ADC_ADDR_W-1:0] addr;
        logic [ADC_DATA_W-1:0] data;
    } init_entry_t;

    // Soft reset, output format, LVDS drive, test pattern off, then datapath setup.
    localparam init_entry_t ADC_INIT_TABLE [ADC_INIT_LEN] = '{
        '{addr: 8'h00, data: 16'h0001},
        '{addr: 8'h01, data: 16'h0000},
        '{addr: 8'h03, data: 16'h0002},
        '{addr: 8'h04, data: 16'h0011},
        '{addr: 8'h05, data: 16'h0000},
        '{addr: 8'h0A, data: 16'h0000},
        '{addr: 8'h0B, data: 16'h00C0},
        '{addr: 8'h0F, data: 16'h0400}
    };

    localparam logic [ADC_DATA_W-1:0] TIMEOUT_RDATA = '1;

endpackage

// File: rtl/adc_spi_rr_arb.sv
// Two-way round-robin arbiter; purely combinational, the grant history
// register lives in the parent.
module adc_spi_rr_arb
(
    input  logic [1:0] valid,
    input  logic       enable,
    input  logic       last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            case (valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/adc_spi_sched.sv
// Sequences ADC register traffic onto the SPI engine: plays the power-up init
// table, then round-robins between the seek (port 0) and debug (port 1) requesters.
module adc_spi_sched
    import adc_spi_pkg::*;
#(
    parameter int unsigned ADDR_W      = ADC_ADDR_W,
    parameter int unsigned DATA_W      = ADC_DATA_W,
    parameter int unsigned INIT_LEN    = ADC_INIT_LEN,
    parameter int unsigned TIMEOUT_CYC = ADC_TIMEOUT_CYC
)
(
    input  logic              clk10m,
    input  logic              sys_rst_n,
    input  logic              start_init,
    input  logic              req0_valid,
    input  logic              req0_rnw,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic              req1_rnw,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              req1_ready,
    output logic              spi_start,
    output logic              spi_rnw,
    output logic [ADDR_W-1:0] spi_addr,
    output logic [DATA_W-1:0] spi_wdata,
    input  logic              spi_done,
    input  logic [DATA_W-1:0] spi_rdata,
    output logic              resp_valid,
    output logic              resp_id,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              init_done,
    output logic              busy,
    output logic              timeout_err
);

    localparam int unsigned IDX_W = $clog2(INIT_LEN) + 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC) + 1;

    state_t            state;
    logic [IDX_W-1:0]  idx;
    logic [CNT_W-1:0]  tmo_cnt;
    logic              last_grant;
    logic              cur_id;
    logic [1:0]        grant;
    logic              arb_en;
    logic              tmo_hit;
    logic              idx_last;
    init_entry_t       entry;

    // start_init takes precedence, so nothing is granted in that cycle.
    assign arb_en   = (state == IDLE) && init_done && !start_init;
    assign tmo_hit  = (tmo_cnt == CNT_W'(TIMEOUT_CYC - 1));
    assign idx_last = (idx == IDX_W'(INIT_LEN - 1));
    assign entry    = ADC_INIT_TABLE[idx[IDX_W-2:0]];

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];

    adc_spi_rr_arb u_arb (
        .valid      ({req1_valid, req0_valid}),
        .enable     (arb_en),
        .last_grant (last_grant),
        .grant      (grant)
    );

    always_ff @(posedge clk10m) begin
        if (!sys_rst_n) begin
            state       <= INIT_ISSUE;
            idx         <= '0;
            tmo_cnt     <= '0;
            last_grant  <= 1'b1;
            cur_id      <= 1'b0;
            spi_start   <= 1'b0;
            spi_rnw     <= 1'b0;
            spi_addr    <= '0;
            spi_wdata   <= '0;
            resp_valid  <= 1'b0;
            resp_id     <= 1'b0;
            resp_rdata  <= '0;
            init_done   <= 1'b0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            spi_start  <= 1'b0;
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_init) begin
                        init_done   <= 1'b0;
                        timeout_err <= 1'b0;
                        idx         <= '0;
                        busy        <= 1'b1;
                        state       <= INIT_ISSUE;
                    end else if (|grant) begin
                        // Fields go straight to the SPI outputs and hold until done.
                        if (grant[1]) begin
                            spi_rnw   <= req1_rnw;
                            spi_addr  <= req1_addr;
                            spi_wdata <= req1_wdata;
                        end else begin
                            spi_rnw   <= req0_rnw;
                            spi_addr  <= req0_addr;
                            spi_wdata <= req0_wdata;
                        end
                        cur_id     <= grant[1];
                        last_grant <= grant[1];
                        spi_start  <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                INIT_ISSUE: begin
                    spi_rnw   <= 1'b0;
                    spi_addr  <= ADDR_W'(entry.addr);
                    spi_wdata <= DATA_W'(entry.data);
                    spi_start <= 1'b1;
                    tmo_cnt   <= '0;
                    busy      <= 1'b1;
                    state     <= INIT_WAIT;
                end
                INIT_WAIT: begin
                    if (spi_done || tmo_hit) begin
                        if (!spi_done) begin
                            timeout_err <= 1'b1;
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx_last) begin
                            init_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            state <= INIT_ISSUE;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                ISSUE: begin
                    tmo_cnt <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (spi_done) begin
                        resp_valid <= 1'b1;
                        resp_id    <= cur_id;
                        resp_rdata <= spi_rnw ? spi_rdata : '0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else if (tmo_hit) begin
                        timeout_err <= 1'b1;
                        resp_valid  <= 1'b1;
                        resp_id     <= cur_id;
                        resp_rdata  <= DATA_W'(TIMEOUT_RDATA);
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
